suc_nbit_ctr: RTL and testbench

//   Parametrised synchronous counter. Successor to the 2-bit count-enable counter.

---
 rtl/suc_nbit_ctr_if.sv | 26 ++
 rtl/suc_nbit_ctr.sv | 84 ++++++++
 tb/tb_suc_nbit_ctr.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/suc_nbit_ctr_if.sv
// Control/status bundle for suc_nbit_ctr.
//   master : drives cte, up, clr, load, din; observes q, tc, ovf, sat
//   slave  : the counter itself (inverse directions)
interface suc_nbit_ctr_if #(
  parameter int WIDTH = 8
) ();
  logic             cte;   // count enable
  logic             up;    // 1 = increment, 0 = decrement
  logic             clr;   // synchronous clear
  logic             load;  // parallel load strobe
  logic [WIDTH-1:0] din;   // parallel load value
  logic [WIDTH-1:0] q;     // registered count
  logic             tc;    // combinational terminal count
  logic             ovf;   // registered 1-cycle range-end pulse
  logic             sat;   // registered pinned-at-end level

  modport master (
    output cte, up, clr, load, din,
    input  q, tc, ovf, sat
  );

  modport slave (
    input  cte, up, clr, load, din,
    output q, tc, ovf, sat
  );
endinterface

// File: rtl/suc_nbit_ctr.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// synchronous clear and wrap/saturate mode. All state updates on the falling
// edge of clk. tc is combinational for cascading (next stage cte = this tc).
// Ports:
//   clk    : clock, state updates on negedge
//   reset  : synchronous active-high reset
//   bus    : suc_nbit_ctr_if.slave (cte, up, clr, load, din -> q, tc, ovf, sat)
module suc_nbit_ctr #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input logic           clk,
  input logic           reset,
  suc_nbit_ctr_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;
  logic             at_max, at_zero;

  always_comb begin
    at_max  = (q_q == MAXV);
    at_zero = (q_q == '0);
  end

  // Priority clr > load > cte; reset is handled in the register block.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    sat_d = sat_q;
    if (bus.clr) begin
      q_d   = '0;
      sat_d = 1'b0;
    end else if (bus.load) begin
      q_d   = (bus.din > MAXV) ? MAXV : bus.din;
      sat_d = 1'b0;
    end else if (bus.cte) begin
      if (bus.up) begin
        if (!at_max) begin
          q_d   = q_q + ONE;
          sat_d = 1'b0;
        end else begin
          ovf_d = 1'b1;
          if (SATURATE) sat_d = 1'b1;
          else          q_d   = '0;
        end
      end else begin
        if (!at_zero) begin
          q_d   = q_q - ONE;
          sat_d = 1'b0;
        end else begin
          ovf_d = 1'b1;
          if (SATURATE) sat_d = 1'b1;
          else          q_d   = MAXV;
        end
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
    end
  end

  always_comb begin
    bus.q   = q_q;
    bus.ovf = ovf_q;
    bus.sat = SATURATE ? sat_q : 1'b0;
    bus.tc  = bus.cte & ((bus.up & at_max) | (~bus.up & at_zero));
  end

endmodule

// File: tb/tb_suc_nbit_ctr.sv
module tb_suc_nbit_ctr;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: wrap, mod 10; dut 1: saturate, mod 10; dut 2: two cascaded mod-16 stages
  suc_nbit_ctr_if #(.WIDTH(4)) a_if ();
  suc_nbit_ctr_if #(.WIDTH(4)) b_if ();
  suc_nbit_ctr_if #(.WIDTH(4)) lo_if ();
  suc_nbit_ctr_if #(.WIDTH(4)) hi_if ();

  suc_nbit_ctr #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  suc_nbit_ctr #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));
  suc_nbit_ctr #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .bus(lo_if.slave));
  suc_nbit_ctr #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .bus(hi_if.slave));

  assign hi_if.cte  = lo_if.tc;
  assign hi_if.up   = lo_if.up;
  assign hi_if.clr  = lo_if.clr;
  assign hi_if.load = lo_if.load;
  assign hi_if.din  = lo_if.din;

  typedef struct {
    int          dut;
    logic [7:0]  q;
    logic        ovf;
    logic        sat;
    logic        tc;
    bit          flags;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int t1q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int t2q [5]  = '{2, 1, 0, 9, 8};

  // Monitor: compares every expectation queued before this sampling edge.
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] aq;
    logic       aovf, asat, atc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin aq = {4'h0, a_if.q}; aovf = a_if.ovf; asat = a_if.sat; atc = a_if.tc; end
        1:       begin aq = {4'h0, b_if.q}; aovf = b_if.ovf; asat = b_if.sat; atc = b_if.tc; end
        default: begin aq = {hi_if.q, lo_if.q}; aovf = hi_if.ovf; asat = hi_if.sat; atc = hi_if.tc; end
      endcase
      checks++;
      if (aq !== e.q) begin
        errors++;
        $display("FAIL %s q: got %0d expected %0d", e.name, aq, e.q);
      end
      if (e.flags) begin
        checks++;
        if (aovf !== e.ovf) begin
          errors++;
          $display("FAIL %s ovf: got %b expected %b", e.name, aovf, e.ovf);
        end
        checks++;
        if (asat !== e.sat) begin
          errors++;
          $display("FAIL %s sat: got %b expected %b", e.name, asat, e.sat);
        end
        checks++;
        if (atc !== e.tc) begin
          errors++;
          $display("FAIL %s tc: got %b expected %b", e.name, atc, e.tc);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next falling edge.
  task automatic step(input int d, input bit rst, input bit cte, input bit up,
                      input bit clr, input bit ld, input logic [7:0] din,
                      input logic [7:0] eq, input bit eovf, input bit esat,
                      input bit etc, input bit fl, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    case (d)
      0:       begin a_if.cte = cte; a_if.up = up; a_if.clr = clr; a_if.load = ld; a_if.din = din[3:0]; end
      1:       begin b_if.cte = cte; b_if.up = up; b_if.clr = clr; b_if.load = ld; b_if.din = din[3:0]; end
      default: begin lo_if.cte = cte; lo_if.up = up; lo_if.clr = clr; lo_if.load = ld; lo_if.din = din[3:0]; end
    endcase
    e.dut = d; e.q = eq; e.ovf = eovf; e.sat = esat; e.tc = etc; e.flags = fl; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    int  m;
    bit  c, ov, tcx;
    reset = 1'b1;
    a_if.cte = 0;  a_if.up = 0;  a_if.clr = 0;  a_if.load = 0;  a_if.din = '0;
    b_if.cte = 0;  b_if.up = 0;  b_if.clr = 0;  b_if.load = 0;  b_if.din = '0;
    lo_if.cte = 0; lo_if.up = 0; lo_if.clr = 0; lo_if.load = 0; lo_if.din = '0;

    // reset state
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_a");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_b");
    step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_casc");

    // count up through the mod-10 wrap
    for (int i = 0; i < 12; i++)
      step(0, 0, 1, 1, 0, 0, 0, 8'(t1q[i]), i == 9, 0, i == 8, 1, "t1_up");

    // load then count down through the wrap
    step(0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 1, "t2_load");
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 0, 0, 0, 0, 8'(t2q[i]), i == 3, 0, i == 2, 1, "t2_down");
    step(0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1, "t2_hold");

    // saturate mode at both ends
    step(1, 0, 0, 1, 0, 1, 8, 8, 0, 0, 0, 1, "t3_load8");
    step(1, 0, 1, 1, 0, 0, 0, 9, 0, 0, 1, 1, "t3_to9");
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 1, 0, 0, 0, 9, 1, 1, 1, 1, "t3_satmax");
    step(1, 0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 1, "t3_off_max");
    step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, "t3_load1");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "t3_to0");
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, "t3_satmin");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "t3_hold_sat");
    step(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, "t3_off_min");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "t3_to0b");
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, "t3_satmin2");
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, "t3_clr_tc");
    step(1, 0, 1, 1, 0, 1, 9, 9, 0, 0, 1, 1, "t3_load_over_cte");
    step(1, 0, 1, 1, 0, 0, 0, 9, 1, 1, 1, 1, "t3_satmax2");
    step(1, 1, 1, 1, 0, 1, 7, 0, 0, 0, 0, 1, "t4_rst_b");

    // load clamp and priority
    step(0, 0, 0, 1, 0, 1, 15, 9, 0, 0, 0, 1, "t4_clamp15");
    step(0, 0, 0, 1, 0, 1, 10, 9, 0, 0, 0, 1, "t4_clamp10");
    step(0, 0, 0, 1, 0, 1, 9, 9, 0, 0, 0, 1, "t4_load9");
    step(0, 0, 0, 1, 1, 1, 15, 0, 0, 0, 0, 1, "t4_clr_load");
    step(0, 0, 0, 1, 0, 1, 5, 5, 0, 0, 0, 1, "t4_load5");
    step(0, 1, 1, 1, 0, 1, 7, 0, 0, 0, 0, 1, "t4_rst_load");

    // two-stage cascade, 300 enabled edges
    step(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "t5_rst");
    for (int k = 1; k <= 300; k++)
      step(2, 0, 1, 1, 0, 0, 0, 8'(k % 256), 0, 0, 0, 0, "t5_casc");
    step(2, 0, 0, 1, 0, 0, 0, 8'h2C, 0, 0, 0, 1, "t5_final");

    // random enable against a reference model, up then down
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, "t6_load0");
    m = 0;
    for (int dir = 1; dir >= 0; dir--) begin
      for (int i = 0; i < 60; i++) begin
        c  = 1'($urandom_range(0, 1));
        ov = 1'b0;
        if (c) begin
          if (dir == 1) begin
            if (m == 9) begin m = 0; ov = 1'b1; end
            else m = m + 1;
          end else begin
            if (m == 0) begin m = 9; ov = 1'b1; end
            else m = m - 1;
          end
        end
        tcx = c && ((dir == 1) ? (m == 9) : (m == 0));
        step(0, 0, c, dir == 1, 0, 0, 0, 8'(m), ov, 0, tcx, 1, "t6_rand");
      end
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
